sum_accum: RTL and testbench
============================

SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 SHALL have parameter N_DATA, default 8, the operand width of the upstream adder; input sum width is N_DATA+1.
REQ-002 SHALL have parameter N_ACC, default 16, the accumulator and result width; legal values satisfy N_ACC >= N_DATA+1.
REQ-003 SHALL have parameter FRAME_LEN, default 4, the number of sums per frame; legal values satisfy FRAME_LEN >= 1.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port i_c, input, N_DATA+1 bits, an unsigned sum from the adder stage.
REQ-007 SHALL have port i_valid, input, 1 bit, which qualifies i_c.
REQ-008 SHALL have port i_last, input, 1 bit, which closes the frame early when accepted with i_c.
REQ-009 SHALL have port o_ready, output, 1 bit, meaning the block can accept i_c this cycle.
REQ-010 SHALL have port o_acc, output, N_ACC bits, the frame total.
REQ-011 SHALL have port o_acc_valid, output, 1 bit, which qualifies o_acc, o_ovf and o_count.
REQ-012 SHALL have port i_acc_ready, input, 1 bit, the downstream consumer's ready.
REQ-013 SHALL have port o_ovf, output, 1 bit, meaning the frame total saturated.
REQ-014 SHALL have port o_count, output, $clog2(FRAME_LEN+1) bits, the number of sums in the frame.

Function
REQ-015 SHALL implement an FSM with states IDLE, ACCUM and HOLD.
REQ-016 SHALL drive o_ready=1 in IDLE and ACCUM, and o_ready=0 in HOLD; o_ready SHALL be registered-state-derived only, with no combinational path from any input.
REQ-017 SHALL accept a beat only when i_valid && o_ready are both high on a rising edge.
- i_c, i_valid and i_last SHALL be ignored when no beat is accepted.
REQ-018 On an accepted beat, SHALL add i_c, zero-extended, to the accumulator and increment the count.
REQ-019 The addition SHALL saturate at 2^N_ACC-1.
- When the unsaturated sum exceeds 2^N_ACC-1, the accumulator SHALL hold 2^N_ACC-1 and the overflow flag SHALL set.
- The overflow flag SHALL stay set (sticky) until the frame is released.
REQ-020 IDLE SHALL go to ACCUM on the first accepted beat, unless that beat also closes the frame, in which case IDLE SHALL go directly to HOLD.
REQ-021 The frame SHALL close on the accepted beat where count reaches FRAME_LEN or i_last=1, whichever comes first; the next state SHALL then be HOLD.
REQ-022 Frame closure SHALL have a latency of 1 cycle: o_acc_valid=1 on the cycle after the closing beat.
- o_acc SHALL include the closing beat.
REQ-023 In HOLD, o_acc, o_ovf, o_count and o_acc_valid SHALL remain stable until i_acc_ready=1.
REQ-024 In HOLD with i_acc_ready=1, the result SHALL be consumed on that edge.
- The next state SHALL be IDLE.
- Accumulator, count and ovf SHALL clear.
- o_acc_valid SHALL drop.
- o_ready SHALL rise on the following cycle; there is no same-cycle bypass.
REQ-025 Outside HOLD, SHALL drive o_acc_valid=0, and o_acc, o_ovf and o_count SHALL show the running internal values.
REQ-026 i_valid gaps SHALL be allowed at any point: a frame spans any number of idle cycles, and the count advances only on accepted beats.
REQ-027 When FRAME_LEN=1, every accepted beat SHALL form its own frame.
REQ-028 An i_last=1 beat that coincides with count reaching FRAME_LEN SHALL close the frame exactly once.

Reset
REQ-029 When rst_n=0, the block SHALL immediately, asynchronously, enter IDLE and drive o_acc=0, o_acc_valid=0, o_ovf=0, o_count=0 and o_ready=1 after release.
REQ-030 A reset asserted mid-frame or in HOLD SHALL discard the partial or unconsumed result; the first frame after release SHALL start from zero.
REQ-031 rst_n SHALL be deasserted synchronously to clk by the system; the block SHALL behave correctly from the first edge after release.

Verification
All scenarios use N_DATA=8, N_ACC=10, FRAME_LEN=4.
REQ-032 Basic frame: sums 10, 20, 30, 40 on consecutive cycles, i_acc_ready=1 -> one cycle after beat 4: o_acc_valid=1, o_acc=100, o_count=4, o_ovf=0; o_ready=0 for exactly 1 cycle.
REQ-033 Early close: 5, then 7 with i_last=1 -> o_acc=12, o_count=2, o_ovf=0; the next frame starts from 0.
REQ-034 Saturation: 510 x4 -> o_acc=1023, o_ovf=1, o_count=4; the next frame of 1, 1, 1, 1 -> o_acc=4, o_ovf=0.
REQ-035 Backpressure: basic frame with i_acc_ready=0 for 3 cycles -> o_acc=100 stable for 4 cycles, o_ready=0 throughout, and i_valid=1 with i_c=99 during HOLD is not counted (the next frame of 1, 2, 3, 4 gives 10).
REQ-036 Gaps and reset: beats 3, 4 separated by 2 idle cycles -> count=2; assert rst_n=0 mid-cycle -> outputs zero immediately; after release, 1, 1, 1, 1 -> o_acc=4.
REQ-037 Each scenario SHALL be checked by queue compare of expected versus observed results, with a timeout watchdog.

Source files
------------

// File: rtl/sum_accum.sv
// Frame accumulator: sums unsigned adder results into a saturating total and
// presents each closed frame (count and overflow included) until it is consumed.
module sum_accum #(
  parameter int N_DATA    = 8,
  parameter int N_ACC     = 16,
  parameter int FRAME_LEN = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_DATA:0]                  i_c,
  input  logic                             i_valid,
  input  logic                             i_last,
  output logic                             o_ready,
  output logic [N_ACC-1:0]                 o_acc,
  output logic                             o_acc_valid,
  input  logic                             i_acc_ready,
  output logic                             o_ovf,
  output logic [$clog2(FRAME_LEN+1)-1:0]   o_count
);

  // state | meaning
  // IDLE  | empty frame, waiting for the first beat
  // ACCUM | frame open, at least one beat accepted
  // HOLD  | frame closed, result held until i_acc_ready

  localparam int CW = $clog2(FRAME_LEN+1);
  localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [N_ACC-1:0]  acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;

  logic              accept;
  logic [N_ACC:0]    sum_ext;
  logic [CW-1:0]     cnt_inc;
  logic              close;

  assign accept  = i_valid && ready_q;
  // One spare bit above the accumulator exposes the carry used for saturation.
  assign sum_ext = {1'b0, acc_q} + {{(N_ACC-N_DATA){1'b0}}, i_c};
  assign cnt_inc = cnt_q + 1'b1;
  assign close   = i_last || (cnt_inc == FRAME_LEN_C);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (sum_ext[N_ACC]) begin
            acc_d = {N_ACC{1'b1}};
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_ext[N_ACC-1:0];
          end
          state_d = close ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (i_acc_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
    ready_d = (state_d != HOLD);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_acc_valid = valid_q;
  assign o_acc       = acc_q;
  assign o_ovf       = ovf_q;
  assign o_count     = cnt_q;

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum (N_DATA=8, N_ACC=10, FRAME_LEN=4): frame results
// are queued and compared against hand-computed expectations.
module tb_sum_accum;

  localparam int N_DATA    = 8;
  localparam int N_ACC     = 10;
  localparam int FRAME_LEN = 4;
  localparam int CW        = $clog2(FRAME_LEN+1);

  logic              clk;
  logic              rst_n;
  logic [N_DATA:0]   i_c;
  logic              i_valid;
  logic              i_last;
  logic              o_ready;
  logic [N_ACC-1:0]  o_acc;
  logic              o_acc_valid;
  logic              i_acc_ready;
  logic              o_ovf;
  logic [CW-1:0]     o_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  sum_accum #(.N_DATA(N_DATA), .N_ACC(N_ACC), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .i_c(i_c), .i_valid(i_valid), .i_last(i_last),
    .o_ready(o_ready), .o_acc(o_acc), .o_acc_valid(o_acc_valid),
    .i_acc_ready(i_acc_ready), .o_ovf(o_ovf), .o_count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_res(input int acc, input int ovf, input int cnt);
    return (acc << 8) | (ovf << 4) | cnt;
  endfunction

  // Entered and left at a falling edge; the rising edge in between takes the beat.
  task automatic send(input int c, input bit last);
    i_valid = 1'b1;
    i_c     = (N_DATA+1)'(c);
    i_last  = last;
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_c     = '0;
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (!o_acc_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!o_acc_valid) check_eq({tag, "_timeout"}, 0, 1);
    obs_q.push_back(pack_res(int'(o_acc), int'(o_ovf), int'(o_count)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_c = '0; i_acc_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_acc", o_acc, 0);
    check_eq("rst_valid", o_acc_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", o_ready, 1);
    check_eq("rst_count", o_count, 0);

    // basic frame, consumer always ready
    send(10, 0); send(20, 0); send(30, 0); send(40, 0);
    check_eq("basic_latency", o_acc_valid, 1);
    wait_result("basic");
    exp_q.push_back(pack_res(100, 0, 4));
    check_eq("basic_ready_low", o_ready, 0);
    @(negedge clk);
    check_eq("basic_ready_back", o_ready, 1);
    check_eq("basic_valid_drop", o_acc_valid, 0);
    check_eq("basic_acc_clear", o_acc, 0);

    // early close via i_last
    send(5, 0);
    check_eq("early_running_acc", o_acc, 5);
    check_eq("early_running_cnt", o_count, 1);
    check_eq("early_running_valid", o_acc_valid, 0);
    send(7, 1);
    wait_result("early");
    exp_q.push_back(pack_res(12, 0, 2));
    @(negedge clk);

    // saturation, then a clean frame
    send(510, 0); send(510, 0); send(510, 0);
    check_eq("sat_running_ovf", o_ovf, 1);
    check_eq("sat_running_acc", o_acc, 1023);
    send(510, 0);
    wait_result("sat");
    exp_q.push_back(pack_res(1023, 1, 4));
    @(negedge clk);
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    wait_result("after_sat");
    exp_q.push_back(pack_res(4, 0, 4));
    @(negedge clk);

    // backpressure with an ignored beat offered during HOLD
    i_acc_ready = 1'b0;
    send(10, 0); send(20, 0); send(30, 0); send(40, 0);
    wait_result("bp");
    exp_q.push_back(pack_res(100, 0, 4));
    i_valid = 1'b1; i_c = 9'd99;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) i_acc_ready = 1'b1;
      check_eq("bp_hold_acc", o_acc, 100);
      check_eq("bp_hold_ready", o_ready, 0);
      check_eq("bp_hold_valid", o_acc_valid, 1);
      @(negedge clk);
    end
    i_valid = 1'b0; i_c = '0;
    check_eq("bp_released_acc", o_acc, 0);
    check_eq("bp_released_ready", o_ready, 1);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    wait_result("bp_next");
    exp_q.push_back(pack_res(10, 0, 4));
    @(negedge clk);

    // gaps, then asynchronous reset mid-frame
    send(3, 0);
    @(negedge clk);
    @(negedge clk);
    check_eq("gap_count_hold", o_count, 1);
    send(4, 0);
    check_eq("gap_count", o_count, 2);
    check_eq("gap_acc", o_acc, 7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_acc", o_acc, 0);
    check_eq("async_rst_count", o_count, 0);
    check_eq("async_rst_ovf", o_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("post_rst_ready", o_ready, 1);
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    wait_result("post_rst");
    exp_q.push_back(pack_res(4, 0, 4));
    @(negedge clk);

    check_eq("result_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq($sformatf("frame%0d", i), obs_q[i], exp_q[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
